ifm_window_fetch: RTL and testbench

IFM_WINDOW_FETCH -- requirements
Module: ifm_window_fetch

---
 rtl/cnn_pkg.sv | 18 +
 rtl/ifm_window_fetch_if.sv | 29 ++
 rtl/win_skid_buf.sv | 52 +++++
 rtl/ifm_window_fetch.sv | 194 +++++++++++++++++++
 tb/tb_ifm_window_fetch.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN definitions for the input-feature-map window fetcher.
//   fetch_state_t : window-fetch controller states
//   ADDR_STEP     : default byte increment between consecutive PE-words
//   KSIZE         : convolution kernel edge length (3x3 windows)
package cnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ROWS,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } fetch_state_t;

  localparam int ADDR_STEP = 4;
  localparam int KSIZE     = 3;

endpackage

// File: rtl/ifm_window_fetch_if.sv
// Buffer-read and window-stream bus of the window fetcher.
//   rd_en/rd_addr/rd_data           : feature-map buffer read port (data 1 cycle after rd_en)
//   out_valid/out_ready/out_data/out_last : window word stream towards the PE array
// master = fetcher side, slave = buffer/consumer side.
interface ifm_window_fetch_if #(
  parameter int PE = 16
);
  logic            rd_en;
  logic [31:0]     rd_addr;
  logic [PE*8-1:0] rd_data;
  logic            out_valid;
  logic            out_ready;
  logic [PE*8-1:0] out_data;
  logic            out_last;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/win_skid_buf.sv
// Two-entry output FIFO between the buffer read pipeline and the consumer.
//   in_valid/in_data/in_last    : word returned by the buffer (no backpressure;
//                                 the fetcher only issues reads that will fit)
//   out_valid/out_ready/out_*   : ready/valid stream to the consumer
//   count                       : current occupancy, used for read admission
module win_skid_buf #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [1:0]    count
);
  logic [DW-1:0] data_q [2];
  logic [1:0]    last_q;
  logic          wr_ptr, rd_ptr;
  logic          push, pop;

  assign push = in_valid;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= in_data;
        last_q[wr_ptr] <= in_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Empty slots are masked so the stream never shows stale words.
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? data_q[rd_ptr] : '0;
  assign out_last  = out_valid && last_q[rd_ptr];

endmodule

// File: rtl/ifm_window_fetch.sv
// 3x3 window fetcher: walks oy, ox, ky, kx, cg over a row-streamed padded
// feature map, reads one PE-word per cycle and forwards it in order.
// Ports: clk, rst_n (async, active-low), start, cfg_c/cfg_w/cfg_pad/cfg_stride2
// (latched on accepted start), row_wr_done (row-ready pulses), bus (read port
// + window stream, master side), busy, done.
// Build option: WIN_FETCH_STRIDE2_EN enables stride 2 via cfg_stride2;
// without it the stride is fixed at 1.
module ifm_window_fetch
  import cnn_pkg::*;
#(
  parameter int PE        = 16,
  parameter int ADDR_STEP = cnn_pkg::ADDR_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          cfg_c,
  input  logic [7:0]          cfg_w,
  input  logic                cfg_pad,
  input  logic                cfg_stride2,
  input  logic                row_wr_done,
  ifm_window_fetch_if.master  bus,
  output logic                busy,
  output logic                done
);
  localparam int         DW     = PE * 8;
  localparam logic [1:0] K_LAST = 2'(KSIZE - 1);

  fetch_state_t state_q, state_d;
  logic [7:0] cg_n, oh, oy, ox, cg;
  logic [8:0] wp, wp_c, rows_avail;
  logic [7:0] oh_c;
  logic [1:0] ky, kx;
  logic [1:0] skid_cnt;
  logic [2:0] occ;
  logic [31:0] row_a, col_a;
  logic start_acc, rd_en_c, space, pop;
  logic win_end, row_end, layer_end, rows_ok, rows_ok_next;
  logic vld_p1, last_p1;

`ifdef WIN_FETCH_STRIDE2_EN
  logic s2;
`else
  logic unused_stride;
  assign unused_stride = cfg_stride2;
`endif

  assign start_acc = start && (state_q == ST_IDLE);
  assign wp_c      = {1'b0, cfg_w} + {7'd0, cfg_pad, 1'b0};
`ifdef WIN_FETCH_STRIDE2_EN
  assign oh_c = 8'(((wp_c - 9'd3) >> cfg_stride2) + 9'd1);
`else
  assign oh_c = 8'(wp_c - 9'd2);
`endif

  // Lowest row count that covers every kernel row of output row y.
  function automatic logic [9:0] rows_needed(input logic [7:0] y);
`ifdef WIN_FETCH_STRIDE2_EN
    return (s2 ? {1'b0, y, 1'b0} : {2'b00, y}) + 10'(KSIZE);
`else
    return {2'b00, y} + 10'(KSIZE);
`endif
  endfunction

  assign rows_ok      = ({1'b0, rows_avail} >= rows_needed(oy)) || (rows_avail == wp);
  assign rows_ok_next = ({1'b0, rows_avail} >= rows_needed(oy + 8'd1)) || (rows_avail == wp);

  assign win_end   = (ky == K_LAST) && (kx == K_LAST) && (cg == cg_n - 8'd1);
  assign row_end   = win_end && (ox == oh - 8'd1);
  assign layer_end = row_end && (oy == oh - 8'd1);

  // Admit a read only if, after this cycle's write and pop, one slot stays
  // free for it; the word arrives one cycle later.
  assign pop   = bus.out_valid && bus.out_ready;
  assign occ   = {1'b0, skid_cnt} + {2'b00, vld_p1} - {2'b00, pop};
  assign space = (occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_en_c = 1'b0;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_WAIT_ROWS;
      ST_WAIT_ROWS: if (rows_ok) state_d = ST_FETCH;
      ST_FETCH: begin
        rd_en_c = space;
        if (space) begin
          if (layer_end)                   state_d = ST_DRAIN;
          else if (row_end && !rows_ok_next) state_d = ST_WAIT_ROWS;
        end
      end
      ST_DRAIN:     if ((skid_cnt == 2'd0) && !vld_p1) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cg_n <= 8'd0;
      wp   <= 9'd0;
      oh   <= 8'd0;
`ifdef WIN_FETCH_STRIDE2_EN
      s2   <= 1'b0;
`endif
    end else if (start_acc) begin
      cg_n <= 8'(32'(cfg_c) / PE);
      wp   <= wp_c;
      oh   <= oh_c;
`ifdef WIN_FETCH_STRIDE2_EN
      s2   <= cfg_stride2;
`endif
    end
  end

  // A row pulse coinciding with start belongs to the new layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               rows_avail <= 9'd0;
    else if (start_acc)                       rows_avail <= {8'd0, row_wr_done};
    else if (row_wr_done && rows_avail != wp) rows_avail <= rows_avail + 9'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || 1'b0) begin
      {oy, ox, cg} <= '0;
      {ky, kx}     <= '0;
    end else if (start_acc) begin
      {oy, ox, cg} <= '0;
      {ky, kx}     <= '0;
    end else if (rd_en_c) begin
      if (cg != cg_n - 8'd1) cg <= cg + 8'd1;
      else begin
        cg <= 8'd0;
        if (kx != K_LAST) kx <= kx + 2'd1;
        else begin
          kx <= 2'd0;
          if (ky != K_LAST) ky <= ky + 2'd1;
          else begin
            ky <= 2'd0;
            if (ox != oh - 8'd1) ox <= ox + 8'd1;
            else begin
              ox <= 8'd0;
              oy <= (oy == oh - 8'd1) ? 8'd0 : oy + 8'd1;
            end
          end
        end
      end
    end
  end

`ifdef WIN_FETCH_STRIDE2_EN
  assign row_a = (s2 ? {23'd0, oy, 1'b0} : {24'd0, oy}) + {30'd0, ky};
  assign col_a = (s2 ? {23'd0, ox, 1'b0} : {24'd0, ox}) + {30'd0, kx};
`else
  assign row_a = {24'd0, oy} + {30'd0, ky};
  assign col_a = {24'd0, ox} + {30'd0, kx};
`endif

  assign bus.rd_en   = rd_en_c;
  assign bus.rd_addr = ((row_a * {23'd0, wp} + col_a) * {24'd0, cg_n} + {24'd0, cg})
                       * 32'(ADDR_STEP);

  // ---- p1: buffer read latency; valid/last travel with the returning word ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= rd_en_c;
      last_p1 <= rd_en_c && win_end;
    end
  end

  win_skid_buf #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (vld_p1),
    .in_data   (bus.rd_data),
    .in_last   (last_p1),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .out_last  (bus.out_last),
    .count     (skid_cnt)
  );

endmodule

// File: tb/tb_ifm_window_fetch.sv
// Randomized self-checking bench for ifm_window_fetch: a buffer model returns
// an address-derived word, and a loop-nest reference model predicts the read
// address order and the window stream.
module tb_ifm_window_fetch;
  localparam int PE    = 16;
  localparam int ASTEP = 4;

  typedef struct {
    logic [31:0] addr;
    logic        last;
  } exp_t;

  logic       clk, rst_n, start, cfg_pad, cfg_stride2, row_wr_done, busy, done;
  logic [7:0] cfg_c, cfg_w;

  ifm_window_fetch_if #(.PE(PE)) bus ();

  ifm_window_fetch #(.PE(PE), .ADDR_STEP(ASTEP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_c       (cfg_c),
    .cfg_w       (cfg_w),
    .cfg_pad     (cfg_pad),
    .cfg_stride2 (cfg_stride2),
    .row_wr_done (row_wr_done),
    .bus         (bus),
    .busy        (busy),
    .done        (done)
  );

  int n_cmp = 0, n_bad = 0;
  int xfer_cnt, last_cnt, done_cnt, rows_pulsed, ready_mode;
  int cur_cgn = 1, cur_wp = 1, n_exp, win_exp;
  logic [31:0] exp_rd[$];
  exp_t        exp_out[$];
  logic [31:0] rd_log[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] data_of(input logic [31:0] a);
    return {a ^ 32'hDEADBEEF, a * 32'd2654435761, ~a, a};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Buffer model: word for the address sampled with rd_en appears next cycle.
  initial begin
    logic t;
    logic [31:0] a;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      t = bus.rd_en;
      a = bus.rd_addr;
      @(posedge clk);
      #1;
      if (t) bus.rd_data = data_of(a);
    end
  end

  // Consumer ready: 0 = always, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    int k;
    k = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
          k++;
        end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: read order, row gating, stream order, hold-under-stall, done count.
  initial begin
    logic [31:0] a;
    exp_t e;
    logic pv, pr, pl;
    logic [127:0] pd;
    pv = 0; pr = 0; pl = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.rd_en) begin
          rd_log.push_back(bus.rd_addr);
          if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
          else begin
            a = exp_rd.pop_front();
            chk("rd_addr", bus.rd_addr, a);
            chk("row_gate", (int'(bus.rd_addr) / ASTEP / cur_cgn / cur_wp) < rows_pulsed, 1);
          end
        end
        if (pv && !pr) begin
          chk("hold_vld", bus.out_valid, 1);
          chk("hold_dat", bus.out_data, pd);
          chk("hold_last", bus.out_last, pl);
        end
        if (bus.out_valid && bus.out_ready) begin
          xfer_cnt++;
          if (bus.out_last) last_cnt++;
          if (exp_out.size() == 0) chk("out_extra", 1, 0);
          else begin
            e = exp_out.pop_front();
            chk("out_data", bus.out_data, data_of(e.addr));
            chk("out_last", bus.out_last, e.last);
          end
        end
        if (done) done_cnt++;
        pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
      end else begin
        pv = 0;
      end
    end
  end

  task automatic build_model(input int c, input int w, input int p, input int s);
    int cgn, wp, oh, a;
    exp_t e;
    exp_rd.delete();
    exp_out.delete();
    cgn = c / PE;
    wp  = w + 2 * p;
    oh  = ((wp - 3) >> (s - 1)) + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < oh; ox++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            for (int g = 0; g < cgn; g++) begin
              a = (((oy * s + ky) * wp + ox * s + kx) * cgn + g) * ASTEP;
              exp_rd.push_back(a);
              e.addr = a;
              e.last = (ky == 2) && (kx == 2) && (g == cgn - 1);
              exp_out.push_back(e);
            end
    cur_cgn = cgn;
    cur_wp  = wp;
    n_exp   = exp_rd.size();
    win_exp = oh * oh;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_rd_en"}, bus.rd_en, 0);
    chk({pfx, "_rd_addr"}, bus.rd_addr, 0);
    chk({pfx, "_out_valid"}, bus.out_valid, 0);
    chk({pfx, "_out_data"}, bus.out_data, 0);
    chk({pfx, "_out_last"}, bus.out_last, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
  endtask

  // rmode: 0 rows back-to-back, 1 withhold after 2 rows, 2 random gaps.
  task automatic run_layer(input int c, input int w, input int p, input int s,
                           input int rmode, input int ymode, input bit poke,
                           input int rst_at);
    int wp, cyc, n, s_eff;
    bit seen;
`ifdef WIN_FETCH_STRIDE2_EN
    s_eff = s;
`else
    s_eff = 1;
`endif
    build_model(c, w, p, s_eff);
    wp = w + 2 * p;
    xfer_cnt = 0; last_cnt = 0; done_cnt = 0; rows_pulsed = 0;
    rd_log.delete();
    ready_mode = ymode;
    @(posedge clk); #1;
    cfg_c = 8'(c); cfg_w = 8'(w); cfg_pad = 1'(p); cfg_stride2 = (s == 2);
    start = 1'b1; row_wr_done = 1'b1; rows_pulsed = 1;
    @(posedge clk); #1;
    start = poke; row_wr_done = 1'b0;
    cfg_c = 8'($urandom); cfg_w = 8'($urandom); cfg_pad = 1'($urandom); cfg_stride2 = 1'($urandom);
    for (int r = 1; r < wp; r++) begin
      if (rmode == 1 && r == 2) begin
        repeat (12) begin
          @(negedge clk);
          chk("wait_rd_en", bus.rd_en, 0);
          chk("wait_busy", busy, 1);
        end
        @(posedge clk); #1;
        row_wr_done = 1'b1; rows_pulsed++;
        @(posedge clk); #1;
        row_wr_done = 1'b0;
        seen = 0;
        repeat (2) begin
          @(negedge clk);
          if (bus.rd_en) seen = 1;
        end
        chk("resume", seen, 1);
      end else begin
        if (rmode == 2) begin
          n = $urandom_range(0, 3);
          repeat (n) begin @(posedge clk); #1; end
        end
        row_wr_done = 1'b1; rows_pulsed++;
        @(posedge clk); #1;
        row_wr_done = 1'b0; start = 1'b0;
      end
    end
    start = 1'b0;
    if (rst_at > 0) begin
      cyc = 0;
      while (xfer_cnt < rst_at && cyc < 20000) begin @(negedge clk); cyc++; end
      chk("reach_word", xfer_cnt >= rst_at, 1);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_zero("rst_mid");
      exp_rd.delete();
      exp_out.delete();
      @(posedge clk); #1 rst_n = 1'b1;
    end else begin
      cyc = 0;
      while (done_cnt == 0 && cyc < 20000) begin @(negedge clk); cyc++; end
      chk("done_seen", done_cnt != 0, 1);
      repeat (4) @(negedge clk);
      chk("done_once", done_cnt, 1);
      chk("n_words", xfer_cnt, n_exp);
      chk("n_win", last_cnt, win_exp);
      chk("rd_left", exp_rd.size(), 0);
      chk("busy_end", busy, 0);
    end
  endtask

  initial begin
    int first_win[9];
    first_win = '{0, 4, 8, 24, 28, 32, 48, 52, 56};
    rst_n = 1'b0; start = 1'b0; row_wr_done = 1'b0;
    cfg_c = 8'd0; cfg_w = 8'd0; cfg_pad = 1'b0; cfg_stride2 = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    run_layer(16, 4, 1, 1, 0, 0, 0, 0);
    chk("base_words", xfer_cnt, 144);
    chk("base_windows", last_cnt, 16);
    for (int i = 0; i < 9; i++) chk("win0_addr", rd_log[i], first_win[i]);

    run_layer(16, 4, 1, 1, 0, 1, 0, 0);
    chk("toggle_words", xfer_cnt, 144);

    run_layer(16, 4, 1, 1, 1, 0, 0, 0);

    run_layer(16, 4, 1, 1, 0, 0, 0, 50);
    run_layer(16, 4, 1, 1, 0, 0, 0, 0);
    chk("restart_n", rd_log.size(), 144);
    chk("restart_a0", rd_log[0], 0);

    run_layer(16, 4, 1, 1, 0, 2, 1, 0);

`ifdef WIN_FETCH_STRIDE2_EN
    run_layer(32, 4, 1, 2, 0, 0, 0, 0);
    chk("s2_words", xfer_cnt, 72);
    chk("s2_win1_a0", rd_log[18], 16);
`endif

    for (int i = 0; i < 6; i++)
      run_layer(16 * $urandom_range(1, 3), $urandom_range(3, 6), $urandom_range(0, 1),
                $urandom_range(1, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
